// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin arbiter that time-shares one pipelined square-root
// core among N_REQ requesters. Operands and results are Q16.16 unsigned.
//
// Handshakes (valid/ready): a request transfers on a rising clk edge where
// req_valid[i] and req_ready[i] are both 1; the requester holds req_valid and
// req_data stable until then. A response transfers on a rising clk edge where
// rsp_valid and rsp_ready are both 1; rsp_data/rsp_id hold until then.
// req_ready is a combinational one-hot grant driven only while idle.
//
// Latency: the operand register changes on the accept edge. The core needs
// SQRT_LAT clocks to present its result, so the result is captured SQRT_LAT+1
// edges after acceptance. cnt counts the edges spent in WAIT.
module sqrt_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 32,
  parameter int SQRT_LAT = 16,
  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  output logic [IW-1:0]       rsp_id,
  output logic [DW-1:0]       rsp_data,
  input  logic                rsp_ready,
  output logic [DW-1:0]       sq_operand,
  input  logic [DW-1:0]       sq_result,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CW = $clog2(SQRT_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SQRT_LAT);

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [IW:0]     scan_sum;
  logic [IW-1:0]   ptr_nxt;
  logic            accept;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (IW + 1)'(k);
      if (scan_sum >= (IW + 1)'(N_REQ)) begin
        scan_sum = scan_sum - (IW + 1)'(N_REQ);
      end
      if (!gnt_found && req_valid[scan_sum[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_sum[IW-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  always_comb begin
    ptr_nxt = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    accept  = (state == ST_IDLE) && gnt_found;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (gnt_found) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == CNT_LAST) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; grant is gated by rst_n so it is 0 in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && accept) begin
      req_ready[gnt_idx] = 1'b1;
    end
    busy      = (state != ST_IDLE);
    rsp_valid = (state == ST_RESP);
    state_dbg = state;
  end

  // Datapath: operand/id capture on accept, cycle count and result capture in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      cnt        <= '0;
      sq_operand <= '0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      if (accept) begin
        sq_operand <= req_data[gnt_idx*DW +: DW];
        rsp_id     <= gnt_idx;
        cnt        <= '0;
        ptr        <= ptr_nxt;
      end else if (state == ST_WAIT) begin
        if (cnt == CNT_LAST) begin
          rsp_data <= sq_result;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: models the core as a SQRT_LAT-deep pipeline of an
// exact Q16.16 square root; a reference model predicts grants and responses.
module tb_sqrt_arbiter;

  localparam int N_REQ    = 4;
  localparam int DW       = 32;
  localparam int SQRT_LAT = 16;
  localparam int IW       = 2;
  localparam int EW       = 32 + IW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ*DW-1:0] req_data = '0;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic [IW-1:0]       rsp_id;
  logic [DW-1:0]       rsp_data;
  logic                rsp_ready = 1'b0;
  logic [DW-1:0]       sq_operand;
  logic [DW-1:0]       sq_result;
  logic                busy;
  logic [1:0]          state_dbg;

  sqrt_arbiter #(.N_REQ(N_REQ), .DW(DW), .SQRT_LAT(SQRT_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .sq_operand(sq_operand), .sq_result(sq_result),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- reference math ----------------
  function automatic logic [DW-1:0] isqrt_q16(input logic [DW-1:0] x);
    logic [63:0] v, r, t;
    v = 64'(x) << 16;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r[DW-1:0];
  endfunction

  // Core model: result of an operand appears SQRT_LAT clocks later.
  logic [DW-1:0] pipe [SQRT_LAT];
  initial for (int i = 0; i < SQRT_LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= isqrt_q16(sq_operand);
    for (int i = 1; i < SQRT_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sq_result = pipe[SQRT_LAT-1];

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];

  logic [N_REQ-1:0] pend_v = '0;
  logic [DW-1:0]    pend_d [N_REQ];
  int               mptr = 0;
  logic             rdy_next = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic post(input int i, input logic [DW-1:0] d);
    pend_v[i] = 1'b1;
    pend_d[i] = d;
  endtask

  // One cycle: drive inputs at negedge, then predict the grant before the edge.
  task automatic tick();
    logic [N_REQ-1:0] oh;
    int g;
    @(negedge clk);
    req_valid = pend_v;
    for (int i = 0; i < N_REQ; i++) req_data[i*DW +: DW] = pend_d[i];
    rsp_ready = rdy_next;
    #1;
    if (rst_n) begin
      if (exp_q.size() == 0 && pend_v != '0) begin
        g = rr_pick(pend_v, mptr);
        oh = '0;
        oh[g] = 1'b1;
        chk("grant", 64'(req_ready), 64'(oh));
        exp_q.push_back({32'(cyc + SQRT_LAT + 2), IW'(g), isqrt_q16(pend_d[g])});
        pend_v[g] = 1'b0;
        mptr = (g + 1) % N_REQ;
      end else begin
        chk("no_grant", 64'(req_ready), 64'd0);
      end
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    rdy_next = 1'b1;
    while ((pend_v != '0 || exp_q.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    if (pend_v != '0 || exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_sq_operand"}, 64'(sq_operand), 64'd0);
    chk({tag, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    pend_v = '0;
    mptr = 0;
  endtask

  // ---------------- monitor ----------------
  logic          prev_v = 1'b0;
  logic          prev_x = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [IW-1:0] prev_id = '0;

  always begin
    logic [EW-1:0] front;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_x = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (!prev_v || prev_x) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stale_rsp actual=rsp_valid=1 required=no_response");
          end else begin
            front = exp_q[0];
            chk("rsp_latency", 64'(cyc), 64'(front[DW+IW +: 32]));
            chk("rsp_id", 64'(rsp_id), 64'(front[DW +: IW]));
            chk("rsp_data", 64'(rsp_data), 64'(front[DW-1:0]));
          end
        end else begin
          chk("hold_data", 64'(rsp_data), 64'(prev_d));
          chk("hold_id", 64'(rsp_id), 64'(prev_id));
        end
        chk("resp_busy", 64'(busy), 64'd1);
        chk("resp_req_ready", 64'(req_ready), 64'd0);
        if (rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        if (prev_x) chk("idle_after_xfer", 64'(busy), 64'd0);
        if (exp_q.size() != 0) begin
          front = exp_q[0];
          if (cyc >= int'(front[DW+IW +: 32]) - SQRT_LAT - 1) begin
            chk("wait_busy", 64'(busy), 64'd1);
            chk("wait_req_ready", 64'(req_ready), 64'd0);
          end
        end
      end
      prev_v  = rsp_valid;
      prev_x  = rsp_valid && rsp_ready;
      prev_d  = rsp_data;
      prev_id = rsp_id;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < N_REQ; i++) pend_d[i] = '0;

    // Reset with requests pending: grants must stay off.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    req_valid = 4'b0101;
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    // Single request on requester 0.
    post(0, 32'h0004_0000);
    wait_drain(60);

    // Contention from a fresh pointer: ids 0,1,2,3 in order.
    @(negedge clk);
    #3 rst_n = 1'b0;
    flush_model();
    #1 chk_reset_outputs("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    post(0, 32'h0004_0000);
    post(1, 32'h0010_0000);
    post(2, 32'h0009_0000);
    post(3, 32'h0001_0000);
    wait_drain(200);

    // Wrap: pointer now back at 0, requesters 0 and 3 -> 0 then 3.
    post(3, 32'h0019_0000);
    post(0, 32'h0002_0000);
    wait_drain(100);

    // Backpressure: hold RESP for 50 clocks with another request pending.
    rdy_next = 1'b0;
    post(1, 32'h0000_4000);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp_reached_resp", 64'(rsp_valid), 64'd1);
    post(2, 32'h1234_5678);
    repeat (50) tick();
    chk("bp_still_valid", 64'(rsp_valid), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);
    wait_drain(100);

    // Reset during WAIT discards the transaction.
    post(2, 32'h0009_0000);
    n = 0;
    while (exp_q.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    repeat (6) tick();
    chk("mid_wait_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_wait");
    flush_model();
    repeat (3) tick();
    #2 rst_n = 1'b1;
    repeat (30) tick();
    post(2, 32'h0009_0000);
    post(0, 32'h0007_0000);
    wait_drain(100);

    // Randomized traffic with random response backpressure.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend_v[i] && $urandom_range(0, 9) == 0) post(i, $urandom);
      end
      rdy_next = ($urandom_range(0, 3) != 0);
      tick();
    end
    wait_drain(400);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
